ipm_xy_router: RTL and testbench

//  Clocked, parametrised input port module for a mesh NoC switch.
//  - Accepts flits from upstream over a 2-phase toggle req/ack link and buffers them in a FIFO.
//  - Decodes each head flit with XY routing and locks one output port for the whole packet.
//  - Forwards flits over per-port 2-phase links.

---
 rtl/ipm_xy_router.sv | 191 +++++++++++++++++++
 tb/tb_ipm_xy_router.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ipm_xy_router.sv
// Input port module for a mesh NoC switch: toggle-link input FIFO, XY route decode with a
// per-packet output lock, per-port toggle-link forwarding and a drop path for bad traffic.
module ipm_xy_router #(
  parameter int WORD_WIDTH = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int COORD_W    = 4,
  parameter int LOC_W      = 3,
  parameter int NUM_LOCAL  = 1,
  parameter int X_LOCAL    = 1,
  parameter int Y_LOCAL    = 1,
  localparam int OUTPORTS  = 4 + NUM_LOCAL
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_up_i,
  input  logic [WORD_WIDTH-1:0] Data_up_i,
  output logic                  ack_up_o,
  output logic [OUTPORTS-1:0]   req_dw_o,
  output logic [WORD_WIDTH-1:0] Data_dw_o,
  input  logic [OUTPORTS-1:0]   ack_dw_i,
  output logic [OUTPORTS-1:0]   PacketEnable_dw_o,
  input  logic [OUTPORTS-1:0]   Grant_dw_i,
  output logic                  drop_o,
  output logic [7:0]            drop_cnt_o
);

  localparam int AW     = $clog2(FIFO_DEPTH);
  localparam int PORT_W = $clog2(OUTPORTS);
  localparam logic [AW:0]        FULL_CNT = (AW+1)'(FIFO_DEPTH);
  localparam logic [COORD_W-1:0] X_L      = COORD_W'(X_LOCAL);
  localparam logic [COORD_W-1:0] Y_L      = COORD_W'(Y_LOCAL);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_GNT,
    S_SEND,
    S_DRAIN,
    S_DROP
  } state_e;

  logic [WORD_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [AW:0]           count_q;
  logic                  ack_up_q;

  state_e                state_q;
  logic [PORT_W-1:0]     port_q;
  logic [OUTPORTS-1:0]   req_dw_q;
  logic [OUTPORTS-1:0]   pe_q;
  logic [WORD_WIDTH-1:0] data_dw_q;
  logic                  drop_q;
  logic [7:0]            drop_cnt_q;

  logic                  empty, full, wr_en, pop;
  logic [WORD_WIDTH-1:0] front;
  logic                  front_is_head, front_is_tail;
  logic [COORD_W-1:0]    dst_x, dst_y;
  logic [LOC_W-1:0]      dst_loc;
  logic [PORT_W-1:0]     route_port;
  logic                  route_ok;
  logic                  lane_free;
  logic [7:0]            drop_cnt_d;

  assign empty         = (count_q == '0);
  assign full          = (count_q == FULL_CNT);
  assign wr_en         = (req_up_i != ack_up_q) && !full;
  assign front         = mem_q[rd_ptr_q];
  assign front_is_head = front[0];  // types 01 and 11
  assign front_is_tail = front[1];  // types 10 and 11
  assign dst_loc       = front[2 +: LOC_W];
  assign dst_y         = front[2+LOC_W +: COORD_W];
  assign dst_x         = front[2+LOC_W+COORD_W +: COORD_W];
  assign lane_free     = (req_dw_q[port_q] == ack_dw_i[port_q]);
  assign drop_cnt_d    = (drop_cnt_q == 8'hFF) ? 8'hFF : drop_cnt_q + 8'd1;

  // XY routing: resolve x first, then y, then pick a local port.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    route_port = '0;
    route_ok   = 1'b1;
    if (dst_x > X_L)      route_port = PORT_W'(0);
    else if (dst_x < X_L) route_port = PORT_W'(1);
    else if (dst_y > Y_L) route_port = PORT_W'(2);
    else if (dst_y < Y_L) route_port = PORT_W'(3);
    else begin
      route_port = PORT_W'(4 + int'(dst_loc));
      route_ok   = (int'(dst_loc) < NUM_LOCAL);
    end
  end

  always_comb begin
    pop = 1'b0;
    case (state_q)
      S_IDLE:  pop = !empty && !front_is_head;
      S_SEND:  pop = !empty && lane_free;
      S_DROP:  pop = !empty;
      default: pop = 1'b0;
    endcase
  end

  // NOTE: the storage array is deliberately not reset; occupancy is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= Data_up_i;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ack_up_q <= 1'b0;
    end else begin
      if (wr_en) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
        ack_up_q <= ~ack_up_q;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({wr_en, pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      port_q     <= '0;
      req_dw_q   <= '0;
      pe_q       <= '0;
      data_dw_q  <= '0;
      drop_q     <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      drop_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (!empty) begin
            if (front_is_head) begin
              if (route_ok) begin
                port_q  <= route_port;
                pe_q    <= OUTPORTS'(1) << route_port;
                state_q <= S_WAIT_GNT;
              end else begin
                state_q <= S_DROP;
              end
            end else begin
              // Stray body/tail with no open packet: discarded by the pop above.
              drop_q     <= 1'b1;
              drop_cnt_q <= drop_cnt_d;
            end
          end
        end
        S_WAIT_GNT: begin
          if (Grant_dw_i[port_q]) state_q <= S_SEND;
        end
        S_SEND: begin
          if (!empty && lane_free) begin
            data_dw_q        <= front;
            req_dw_q[port_q] <= ~req_dw_q[port_q];
            if (front_is_tail) state_q <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          // Hold the lock until the tail has been acknowledged downstream.
          if (lane_free) begin
            pe_q    <= '0;
            state_q <= S_IDLE;
          end
        end
        S_DROP: begin
          if (!empty && front_is_tail) begin
            drop_q     <= 1'b1;
            drop_cnt_q <= drop_cnt_d;
            state_q    <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign ack_up_o          = ack_up_q;
  assign req_dw_o          = req_dw_q;
  assign Data_dw_o         = data_dw_q;
  assign PacketEnable_dw_o = pe_q;
  assign drop_o            = drop_q;
  assign drop_cnt_o        = drop_cnt_q;

endmodule

// File: tb/tb_ipm_xy_router.sv
// Directed bench for ipm_xy_router (X_LOCAL=1, Y_LOCAL=1, FIFO_DEPTH=4, one local port):
// upstream toggle pushes, auto/held downstream acks, and a monitor logging forwarded flits.
module tb_ipm_xy_router;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_up_i;
  logic [31:0] Data_up_i;
  logic        ack_up_o;
  logic [4:0]  req_dw_o;
  logic [31:0] Data_dw_o;
  logic [4:0]  ack_dw_i;
  logic [4:0]  pe;
  logic [4:0]  grant;
  logic        drop_o;
  logic [7:0]  drop_cnt;

  int checks = 0;
  int failures = 0;

  bit          auto_ack = 1'b0;
  logic [31:0] out_data_q[$];
  int          out_port_q[$];
  logic [4:0]  pe_log[$];
  int          drop_pulses = 0;
  bit          pe_multi = 1'b0;
  logic [4:0]  req_prev, pe_prev;

  ipm_xy_router dut (
    .clk               (clk),
    .reset             (reset),
    .req_up_i          (req_up_i),
    .Data_up_i         (Data_up_i),
    .ack_up_o          (ack_up_o),
    .req_dw_o          (req_dw_o),
    .Data_dw_o         (Data_dw_o),
    .ack_dw_i          (ack_dw_i),
    .PacketEnable_dw_o (pe),
    .Grant_dw_i        (grant),
    .drop_o            (drop_o),
    .drop_cnt_o        (drop_cnt)
  );

  always #5 clk = ~clk;

  // Downstream receiver: acknowledges every request half a cycle later when enabled.
  initial begin
    forever begin
      @(negedge clk);
      if (auto_ack) ack_dw_i = req_dw_o;
    end
  end

  // Output monitor, sampled 1 time unit after each active edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (reset) begin
        req_prev = req_dw_o;
        pe_prev  = pe;
      end else begin
        for (int p = 0; p < 5; p++) begin
          if (req_dw_o[p] != req_prev[p]) begin
            out_data_q.push_back(Data_dw_o);
            out_port_q.push_back(p);
          end
        end
        req_prev = req_dw_o;
        if (pe != pe_prev) pe_log.push_back(pe);
        pe_prev = pe;
        if (drop_o) drop_pulses++;
        if ($countones(pe) > 1) pe_multi = 1'b1;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_logs();
    out_data_q.delete();
    out_port_q.delete();
    pe_log.delete();
    drop_pulses = 0;
  endtask

  task automatic push(input logic [31:0] d, input int bound, output bit ok);
    int n = 0;
    Data_up_i = d;
    req_up_i  = ~req_up_i;
    do begin
      @(negedge clk);
      n++;
    end while (ack_up_o !== req_up_i && n < bound);
    ok = (ack_up_o === req_up_i);
  endtask

  task automatic push_chk(input string tag, input logic [31:0] d);
    bit ok;
    push(d, 6, ok);
    check(tag, 32'(ok), 32'd1);
  endtask

  task automatic wait_pe(input string tag, input logic [4:0] v, input int bound);
    int n = 0;
    while (pe !== v && n < bound) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(pe), 32'(v));
  endtask

  task automatic wait_out(input string tag, input int cnt, input int bound);
    int n = 0;
    while (out_data_q.size() < cnt && n < bound) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(out_data_q.size()), 32'(cnt));
  endtask

  task automatic check_out(input string tag, input int idx, input int port, input logic [31:0] d);
    logic [31:0] op = 32'hDEAD_BEEF;
    logic [31:0] od = 32'hDEAD_BEEF;
    if (idx < out_data_q.size()) begin
      op = 32'(out_port_q[idx]);
      od = out_data_q[idx];
    end
    check({tag, "_port"}, op, 32'(port));
    check({tag, "_data"}, od, d);
  endtask

  task automatic check_pe_log(input string tag, input int idx, input logic [4:0] v);
    logic [4:0] o = 5'h1F;
    if (idx < pe_log.size()) o = pe_log[idx];
    check(tag, 32'(o), 32'(v));
  endtask

  initial begin
    bit ok, sixth_ok;
    int accepted, bad;

    reset     = 1'b1;
    req_up_i  = 1'b0;
    Data_up_i = '0;
    ack_dw_i  = '0;
    grant     = 5'b11111;
    tick(3);
    check("rst_ack_up",   32'(ack_up_o), 32'd0);
    check("rst_req_dw",   32'(req_dw_o), 32'd0);
    check("rst_data_dw",  Data_dw_o,     32'd0);
    check("rst_pe",       32'(pe),       32'd0);
    check("rst_drop",     32'(drop_o),   32'd0);
    check("rst_drop_cnt", 32'(drop_cnt), 32'd0);
    reset    = 1'b0;
    auto_ack = 1'b1;
    tick(1);
    clear_logs();

    // Packet to the east (x=2,y=0): head 0x401, two bodies, tail.
    push_chk("t1_head_acc", 32'h0000_0401);
    wait_pe("t1_pe_set", 5'b00001, 10);
    push_chk("t1_b0_acc", 32'h0000_0000);
    push_chk("t1_b1_acc", 32'hFFFF_FFFC);
    push_chk("t1_tail_acc", 32'h0000_0002);
    wait_out("t1_out_n", 4, 40);
    wait_pe("t1_pe_clr", 5'b00000, 20);
    check_out("t1_f0", 0, 0, 32'h0000_0401);
    check_out("t1_f1", 1, 0, 32'h0000_0000);
    check_out("t1_f2", 2, 0, 32'hFFFF_FFFC);
    check_out("t1_f3", 3, 0, 32'h0000_0002);
    check("t1_pe_log_n", 32'(pe_log.size()), 32'd2);
    check_pe_log("t1_pe_log0", 0, 5'b00001);
    check_pe_log("t1_pe_log1", 1, 5'b00000);

    // North packet (x=1,y=3) then a single-flit local packet (x=1,y=1,loc=0).
    clear_logs();
    push_chk("t2_h1_acc", 32'h0000_0261);
    push_chk("t2_t1_acc", 32'h0000_0002);
    push_chk("t2_h2_acc", 32'h0000_0223);
    wait_out("t2_out_n", 3, 60);
    wait_pe("t2_pe_clr", 5'b00000, 20);
    check_out("t2_f0", 0, 2, 32'h0000_0261);
    check_out("t2_f1", 1, 2, 32'h0000_0002);
    check_out("t2_f2", 2, 4, 32'h0000_0223);
    check("t2_pe_log_n", 32'(pe_log.size()), 32'd4);
    check_pe_log("t2_pe_log0", 0, 5'b00100);
    check_pe_log("t2_pe_log1", 1, 5'b00000);
    check_pe_log("t2_pe_log2", 2, 5'b10000);
    check_pe_log("t2_pe_log3", 3, 5'b00000);

    // Backpressure: downstream ack held, six flits offered, only five accepted.
    clear_logs();
    auto_ack = 1'b0;
    accepted = 0;
    sixth_ok = 1'b1;
    push(32'h0000_0401, 4, ok);
    accepted += int'(ok);
    for (int i = 1; i <= 5; i++) begin
      push(32'h1000_0000 + 32'(i << 2), 4, ok);
      accepted += int'(ok);
      if (i == 5) sixth_ok = ok;
    end
    check("t3_accepted", 32'(accepted), 32'd5);
    check("t3_sixth_held", 32'(sixth_ok), 32'd0);
    check("t3_out_n_held", 32'(out_data_q.size()), 32'd1);
    check_out("t3_f0", 0, 0, 32'h0000_0401);
    auto_ack = 1'b1;
    bad = 0;
    while (ack_up_o !== req_up_i && bad < 10) begin
      @(negedge clk);
      bad++;
    end
    check("t3_sixth_acc", 32'(ack_up_o), 32'(req_up_i));
    push_chk("t3_tail_acc", 32'h0000_0002);
    wait_out("t3_out_n", 7, 60);
    wait_pe("t3_pe_clr", 5'b00000, 20);
    check_out("t3_f5", 5, 0, 32'h1000_0014);
    check_out("t3_f6", 6, 0, 32'h0000_0002);

    // Illegal local port (loc=5): whole packet dropped.
    clear_logs();
    push_chk("t4_h_acc", 32'h0000_0235);
    push_chk("t4_b0_acc", 32'h0000_0010);
    push_chk("t4_b1_acc", 32'h0000_0014);
    push_chk("t4_t_acc", 32'h0000_0002);
    tick(10);
    check("t4_drop_pulses", 32'(drop_pulses), 32'd1);
    check("t4_drop_cnt", 32'(drop_cnt), 32'd1);
    check("t4_out_n", 32'(out_data_q.size()), 32'd0);
    check("t4_pe_log_n", 32'(pe_log.size()), 32'd0);

    // Lone tail in IDLE is discarded, then a head+tail to port 0.
    clear_logs();
    push_chk("t5_tail_acc", 32'h0000_0002);
    tick(5);
    check("t5_drop_pulses", 32'(drop_pulses), 32'd1);
    check("t5_drop_cnt", 32'(drop_cnt), 32'd2);
    check("t5_out_n_stray", 32'(out_data_q.size()), 32'd0);
    push_chk("t5_ht_acc", 32'h0000_0403);
    wait_out("t5_out_n", 1, 20);
    wait_pe("t5_pe_clr", 5'b00000, 20);
    check_out("t5_f0", 0, 0, 32'h0000_0403);
    check("t5_pe_log_n", 32'(pe_log.size()), 32'd2);

    // Grant withheld for 20 cycles, then reset mid-packet.
    clear_logs();
    grant = 5'b00000;
    push_chk("t6_h_acc", 32'h0000_0401);
    wait_pe("t6_pe_set", 5'b00001, 10);
    bad = 0;
    repeat (20) begin
      tick(1);
      if (pe !== 5'b00001 || out_data_q.size() != 0) bad++;
    end
    check("t6_pe_held_no_req", 32'(bad), 32'd0);
    auto_ack = 1'b0;
    grant    = 5'b00001;
    wait_out("t6_out_n", 1, 10);
    check_out("t6_f0", 0, 0, 32'h0000_0401);
    push_chk("t6_b0_acc", 32'h0000_0100);
    push_chk("t6_b1_acc", 32'h0000_0104);
    reset    = 1'b1;
    req_up_i = 1'b0;
    ack_dw_i = '0;
    tick(1);
    check("t6_rst_ack_up",   32'(ack_up_o), 32'd0);
    check("t6_rst_req_dw",   32'(req_dw_o), 32'd0);
    check("t6_rst_data_dw",  Data_dw_o,     32'd0);
    check("t6_rst_pe",       32'(pe),       32'd0);
    check("t6_rst_drop",     32'(drop_o),   32'd0);
    check("t6_rst_drop_cnt", 32'(drop_cnt), 32'd0);
    reset    = 1'b0;
    grant    = 5'b11111;
    auto_ack = 1'b1;
    clear_logs();
    tick(4);
    check("t6_quiet_out_n", 32'(out_data_q.size()), 32'd0);
    check("t6_quiet_pe", 32'(pe), 32'd0);
    push_chk("t6_ht_acc", 32'h0000_0403);
    wait_out("t6_post_out_n", 1, 20);
    wait_pe("t6_post_pe_clr", 5'b00000, 20);
    check_out("t6_post_f0", 0, 0, 32'h0000_0403);
    check("t6_post_drop_cnt", 32'(drop_cnt), 32'd0);

    check("pe_onehot", 32'(pe_multi), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
